map_collision_scanner: RTL

- Consumer side of the world-map description bus. Reads the packed ground, fence, exit and spike arrays that a world_map module drives.
- On each start pulse, scans every entry sequentially against the player bounding box and reports registered collision flags: grounded, wall blocks, spike hit and exit reached.
- Sits between the world map and the player-motion controller. The controller issues one start per frame.

---
 rtl/map_collision_scanner_if.sv | 31 +++
 rtl/map_collision_scanner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/map_collision_scanner_if.sv
// Map description bus plus the scan request/result signals shared between the
// motion controller, the world map and the collision scanner.
interface map_collision_scanner_if;
  logic                  start;
  logic [9:0]            px;
  logic [8:0]            py;
  logic [15:0][28:0]     info_ground;
  logic [15:0][28:0]     info_fence;
  logic [1:0][9:0]       info_exit;
  logic [5:0][20:0]      info_spince;
  logic                  busy;
  logic                  done;
  logic                  grounded;
  logic [8:0]            ground_y;
  logic                  blocked_left;
  logic                  blocked_right;
  logic                  hit_spike;
  logic                  at_exit;

  modport master (
    output start, px, py, info_ground, info_fence, info_exit, info_spince,
    input  busy, done, grounded, ground_y, blocked_left, blocked_right,
           hit_spike, at_exit
  );

  modport slave (
    input  start, px, py, info_ground, info_fence, info_exit, info_spince,
    output busy, done, grounded, ground_y, blocked_left, blocked_right,
           hit_spike, at_exit
  );
endinterface

// File: rtl/map_collision_scanner.sv
// Sequential collision scanner: walks ground, fence and spike entries one per
// cycle against a latched player box, then publishes registered flags with done.
module map_collision_scanner #(
  parameter int PLAYER_W   = 16,
  parameter int PLAYER_H   = 24,
  parameter int GROUND_TOL = 2,
  parameter int WALL_TOL   = 1,
  parameter int SPIKE_R    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  map_collision_scanner_if.slave  bus
);

  localparam logic [10:0] PW = 11'(PLAYER_W);
  localparam logic [10:0] PH = 11'(PLAYER_H);
  localparam logic [10:0] GT = 11'(GROUND_TOL);
  localparam logic [10:0] WT = 11'(WALL_TOL);
  localparam logic [10:0] SR = 11'(SPIKE_R);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GROUND,
    S_FENCE,
    S_SPIKE,
    S_EXIT,
    S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  idx_reg, idx_next;
  logic [9:0]  px_reg;
  logic [8:0]  py_reg;

  logic        acc_grounded_reg;
  logic [8:0]  acc_ground_y_reg;
  logic        acc_left_reg;
  logic        acc_right_reg;
  logic        acc_spike_reg;
  logic        acc_exit_reg;

  logic        busy_reg;
  logic        done_reg;
  logic        grounded_reg;
  logic [8:0]  ground_y_reg;
  logic        blocked_left_reg;
  logic        blocked_right_reg;
  logic        hit_spike_reg;
  logic        at_exit_reg;

  logic        accept;
  assign accept = (state_reg == S_IDLE) && bus.start;

  // State/index sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_GROUND;
          idx_next   = 4'd0;
        end
      end
      S_GROUND: begin
        idx_next = idx_reg + 4'd1;
        if (idx_reg == 4'd15) begin
          state_next = S_FENCE;
          idx_next   = 4'd0;
        end
      end
      S_FENCE: begin
        idx_next = idx_reg + 4'd1;
        if (idx_reg == 4'd15) begin
          state_next = S_SPIKE;
          idx_next   = 4'd0;
        end
      end
      S_SPIKE: begin
        idx_next = idx_reg + 4'd1;
        if (idx_reg == 4'd5) begin
          state_next = S_EXIT;
          idx_next   = 4'd0;
        end
      end
      S_EXIT:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: begin
        state_next = S_IDLE;
        idx_next   = 4'd0;
      end
    endcase
  end

  // Entry decode, all widened to 11 bits so sums never wrap
  logic [28:0] ground_entry, fence_entry;
  logic [20:0] spike_entry;

  assign ground_entry = bus.info_ground[idx_reg];
  assign fence_entry  = bus.info_fence[idx_reg];

  always_comb begin
    spike_entry = '0;
    for (int i = 0; i < 6; i++) begin
      if (idx_reg == 4'(i)) spike_entry = bus.info_spince[i];
    end
  end

  logic [10:0] px_w, py_w, feet, right_edge;
  assign px_w       = {1'b0, px_reg};
  assign py_w       = {2'b0, py_reg};
  assign feet       = py_w + PH;
  assign right_edge = px_w + PW;

  logic [10:0] g_x, g_y, g_len;
  logic        g_match;
  assign g_x   = {1'b0, ground_entry[9:0]};
  assign g_y   = {2'b0, ground_entry[18:10]};
  assign g_len = {1'b0, ground_entry[28:19]};
  assign g_match = (g_len != 11'd0) && (g_y <= feet) && (feet <= g_y + GT) &&
                   (right_edge > g_x) && (px_w < g_x + g_len);

  logic [10:0] f_y, f_x, f_len;
  logic        f_overlap, f_right, f_left;
  assign f_y   = {2'b0, fence_entry[8:0]};
  assign f_x   = {1'b0, fence_entry[18:9]};
  assign f_len = {1'b0, fence_entry[28:19]};
  assign f_overlap = (f_len != 11'd0) && (py_w < f_y + f_len) && (feet > f_y);
  assign f_right   = f_overlap && (right_edge <= f_x) && (f_x <= right_edge + WT);
  assign f_left    = f_overlap && (f_x <= px_w) && (px_w <= f_x + WT);

  logic [10:0] s_x, s_y, s_xlo, s_ylo;
  logic        s_hit;
  assign s_x   = {1'b0, spike_entry[9:0]};
  assign s_y   = {2'b0, spike_entry[18:10]};
  assign s_xlo = (s_x >= SR) ? (s_x - SR) : 11'd0;
  assign s_ylo = (s_y >= SR) ? (s_y - SR) : 11'd0;
  assign s_hit = (spike_entry[18:0] != 19'd0) &&
                 (px_w < s_x + SR) && (right_edge > s_xlo) &&
                 (py_w < s_y + SR) && (feet > s_ylo);

  // Spike direction has no effect on the hit box
  logic unused_dir;
  assign unused_dir = ^spike_entry[20:19];

  logic [10:0] e_x, e_y;
  logic        e_match;
  assign e_x = {1'b0, bus.info_exit[0]};
  assign e_y = {1'b0, bus.info_exit[1]};
  assign e_match = (px_w <= e_x) && (e_x < right_edge) &&
                   (py_w <= e_y) && (e_y < feet);

  // Accumulators and latched player box
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_reg           <= '0;
      py_reg           <= '0;
      acc_grounded_reg <= 1'b0;
      acc_ground_y_reg <= 9'd511;
      acc_left_reg     <= 1'b0;
      acc_right_reg    <= 1'b0;
      acc_spike_reg    <= 1'b0;
      acc_exit_reg     <= 1'b0;
    end else if (accept) begin
      px_reg           <= bus.px;
      py_reg           <= bus.py;
      acc_grounded_reg <= 1'b0;
      acc_ground_y_reg <= 9'd511;
      acc_left_reg     <= 1'b0;
      acc_right_reg    <= 1'b0;
      acc_spike_reg    <= 1'b0;
      acc_exit_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_GROUND: begin
          if (g_match) begin
            acc_grounded_reg <= 1'b1;
            if (g_y[8:0] < acc_ground_y_reg) acc_ground_y_reg <= g_y[8:0];
          end
        end
        S_FENCE: begin
          if (f_left)  acc_left_reg  <= 1'b1;
          if (f_right) acc_right_reg <= 1'b1;
        end
        S_SPIKE: if (s_hit) acc_spike_reg <= 1'b1;
        S_EXIT:  acc_exit_reg <= e_match;
        default: ;
      endcase
    end
  end

  // Published results change only on the done cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      grounded_reg      <= 1'b0;
      ground_y_reg      <= 9'd511;
      blocked_left_reg  <= 1'b0;
      blocked_right_reg <= 1'b0;
      hit_spike_reg     <= 1'b0;
      at_exit_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        busy_reg <= 1'b1;
      end else if (state_reg == S_DONE) begin
        busy_reg          <= 1'b0;
        done_reg          <= 1'b1;
        grounded_reg      <= acc_grounded_reg;
        ground_y_reg      <= acc_ground_y_reg;
        blocked_left_reg  <= acc_left_reg;
        blocked_right_reg <= acc_right_reg;
        hit_spike_reg     <= acc_spike_reg;
        at_exit_reg       <= acc_exit_reg;
      end
    end
  end

  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;
  assign bus.grounded      = grounded_reg;
  assign bus.ground_y      = ground_y_reg;
  assign bus.blocked_left  = blocked_left_reg;
  assign bus.blocked_right = blocked_right_reg;
  assign bus.hit_spike     = hit_spike_reg;
  assign bus.at_exit       = at_exit_reg;

endmodule
